bc_scheduler: RTL and testbench



---
 rtl/bc_scheduler.sv | 148 ++++++++++++++
 tb/tb_bc_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bc_scheduler.sv
// rtl/bc_scheduler.sv - broadcast ping-pong buffer fill/drain sequencer
// One buffer fills with load beats while the other is re-read pass by pass on lane 0.
module bc_scheduler #(
  parameter int NrLanes = 4,
  parameter int MaxBlen = 64,
  parameter int MaxReps = 256
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [$clog2(MaxBlen+1)-1:0] cmd_blen_i,
  input  logic [$clog2(MaxReps+1)-1:0] cmd_reps_i,
  input  logic                         wr_beat_i,
  output logic                         wr_en_o,
  output logic                         wr_buf_o,
  input  logic                         rd_ready_i,
  output logic                         rd_valid_o,
  output logic                         rd_buf_o,
  output logic                         rd_pop_o,
  output logic                         rd_last_o,
  output logic                         rd_rewind_o,
  output logic                         rd_invalidate_o,
  output logic                         busy_o,
  output logic                         err_o
);
  localparam int BW        = $clog2(MaxBlen+1);
  localparam int RW        = $clog2(MaxReps+1);
  localparam int BeatElems = 2*NrLanes;

  typedef enum logic [1:0] {IDLE, FILL, FULL, DRAIN} buf_state_e;

  buf_state_e    state_q [2];
  buf_state_e    state_d [2];
  logic [BW-1:0] blen_q  [2];
  logic [BW-1:0] blen_d  [2];
  logic [RW-1:0] reps_q  [2];
  logic [RW-1:0] reps_d  [2];
  logic          wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [BW-1:0] beat_q, beat_d, elem_q, elem_d;
  logic [RW-1:0] pass_q, pass_d;
  logic          err_q, err_d;
  logic          fill_any, accept, more_passes;
  logic [BW:0]   beats_need;
  logic [BW-1:0] rd_blen;
  logic [RW-1:0] rd_reps;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= IDLE;
        blen_q[i]  <= '0;
        reps_q[i]  <= '0;
      end
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      beat_q   <= '0;
      elem_q   <= '0;
      pass_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        state_q[i] <= state_d[i];
        blen_q[i]  <= blen_d[i];
        reps_q[i]  <= reps_d[i];
      end
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      beat_q   <= beat_d;
      elem_q   <= elem_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    blen_d   = blen_q;
    reps_d   = reps_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    beat_d   = beat_q;
    elem_d   = elem_q;
    pass_d   = pass_q;
    err_d    = err_q;

    fill_any    = (state_q[0] == FILL) || (state_q[1] == FILL);
    cmd_ready_o = (state_q[wr_sel_q] == IDLE) && !fill_any;
    accept      = cmd_valid_i && cmd_ready_o;
    wr_en_o     = fill_any;
    wr_buf_o    = wr_sel_q;
    busy_o      = (state_q[0] != IDLE) || (state_q[1] != IDLE);
    err_o       = err_q;
    beats_need  = ({1'b0, blen_q[wr_sel_q]} + (BW+1)'(BeatElems-1)) / (BW+1)'(BeatElems);

    // Zero lengths/counts are promoted to one so every command drains at least once.
    if (accept) begin
      state_d[wr_sel_q] = FILL;
      blen_d[wr_sel_q]  = (cmd_blen_i == '0) ? BW'(1) : cmd_blen_i;
      reps_d[wr_sel_q]  = (cmd_reps_i == '0) ? RW'(1) : cmd_reps_i;
      beat_d            = '0;
    end

    if (wr_beat_i) begin
      if (fill_any) begin
        if (({1'b0, beat_q} + (BW+1)'(1)) == beats_need) begin
          state_d[wr_sel_q] = FULL;
          wr_sel_d          = ~wr_sel_q;
          beat_d            = '0;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end else begin
        err_d = 1'b1;
      end
    end

    rd_blen         = blen_q[rd_sel_q];
    rd_reps         = reps_q[rd_sel_q];
    more_passes     = pass_q < (rd_reps - RW'(1));
    rd_buf_o        = rd_sel_q;
    rd_valid_o      = state_q[rd_sel_q] == DRAIN;
    rd_pop_o        = rd_valid_o && rd_ready_i;
    rd_last_o       = rd_pop_o && (elem_q == (rd_blen - BW'(1)));
    rd_rewind_o     = rd_last_o && more_passes;
    rd_invalidate_o = rd_last_o && !more_passes;

    if (state_q[rd_sel_q] == FULL) begin
      state_d[rd_sel_q] = DRAIN;
      elem_d            = '0;
      pass_d            = '0;
    end

    if (rd_pop_o) begin
      if (rd_last_o) begin
        elem_d = '0;
        if (more_passes) begin
          pass_d = pass_q + RW'(1);
        end else begin
          state_d[rd_sel_q] = IDLE;
          rd_sel_d          = ~rd_sel_q;
        end
      end else begin
        elem_d = elem_q + BW'(1);
      end
    end
  end
endmodule

// File: tb/tb_bc_scheduler.sv
// tb/tb_bc_scheduler.sv - directed self-checking bench for bc_scheduler
module tb_bc_scheduler;
  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic [6:0] cmd_blen_i = '0;
  logic [8:0] cmd_reps_i = '0;
  logic       wr_beat_i = 1'b0;
  logic       wr_en_o, wr_buf_o;
  logic       rd_ready_i = 1'b0;
  logic       rd_valid_o, rd_buf_o, rd_pop_o, rd_last_o, rd_rewind_o, rd_invalidate_o;
  logic       busy_o, err_o;

  int n_tests = 0;
  int n_fail  = 0;
  int fp_a, fp_b, pops;

  bc_scheduler #(.NrLanes(4), .MaxBlen(64), .MaxReps(256)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_blen_i(cmd_blen_i), .cmd_reps_i(cmd_reps_i),
    .wr_beat_i(wr_beat_i), .wr_en_o(wr_en_o), .wr_buf_o(wr_buf_o),
    .rd_ready_i(rd_ready_i), .rd_valid_o(rd_valid_o), .rd_buf_o(rd_buf_o),
    .rd_pop_o(rd_pop_o), .rd_last_o(rd_last_o), .rd_rewind_o(rd_rewind_o),
    .rd_invalidate_o(rd_invalidate_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {cmd_ready_o, wr_en_o, wr_buf_o, rd_valid_o, rd_buf_o, rd_pop_o,
            rd_last_o, rd_rewind_o, rd_invalidate_o, busy_o, err_o};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_cmd(input string tag, input int blen, input int reps, input bit exp_ready);
    cmd_valid_i = 1'b1;
    cmd_blen_i  = 7'(blen);
    cmd_reps_i  = 9'(reps);
    @(negedge clk_i);
    check({tag, "_cmd_ready"}, cmd_ready_o, exp_ready);
    step();
    cmd_valid_i = 1'b0;
  endtask

  // Returns at the negedge where wr_en_o is first seen low again.
  task automatic fill(input string tag, input int exp_beats, input bit exp_buf);
    int beats = 0;
    bit done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk_i);
      if (wr_en_o) begin
        if (beats == 0) check({tag, "_wr_buf"}, wr_buf_o, exp_buf);
        wr_beat_i = 1'b1;
        beats++;
        @(posedge clk_i);
        #1;
        wr_beat_i = 1'b0;
      end else begin
        done = 1;
      end
    end
    check({tag, "_beats"}, beats, exp_beats);
  endtask

  task automatic drain(input string tag, input int blen, input int reps, input bit exp_buf,
                       input bit use_pat, output int first_pop);
    int np = 0;
    int cyc = 0;
    bit done = 0;
    bit el, er, ei;
    logic [31:0] pat = 32'hB6D5_3A9C;
    first_pop = -1;
    while (!done && cyc < 600) begin
      rd_ready_i = use_pat ? pat[cyc % 32] : 1'b1;
      @(negedge clk_i);
      if (!rd_ready_i) check({tag, "_nopop"}, rd_pop_o, 0);
      if (rd_pop_o) begin
        np++;
        if (first_pop < 0) begin
          first_pop = cyc;
          check({tag, "_rd_buf"}, rd_buf_o, exp_buf);
        end
        el = (np % blen) == 0;
        ei = np == blen * reps;
        er = el && !ei;
        check({tag, "_pulse"}, {rd_last_o, rd_rewind_o, rd_invalidate_o}, {el, er, ei});
        done = rd_invalidate_o || (np >= blen * reps);
      end
      cyc++;
      step();
    end
    check({tag, "_pops"}, np, blen * reps);
  endtask

  task automatic run_s1(input string tag);
    int fp;
    send_cmd(tag, 16, 3, 1'b1);
    fill(tag, 2, 1'b0);
    check({tag, "_full_not_drain"}, rd_valid_o, 0);
    step();
    drain(tag, 16, 3, 1'b0, 1'b0, fp);
    check({tag, "_drain_latency"}, fp, 0);
    rd_ready_i = 1'b0;
    @(negedge clk_i);
    check({tag, "_busy_after"}, busy_o, 0);
    step();
  endtask

  initial begin
    step();
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_outs", outs(), 11'b100_0000_0000);
    step();

    // Ping-pong: B fills buffer 1 while A drains buffer 0.
    send_cmd("pp_a", 8, 4, 1'b1);
    fill("pp_a", 1, 1'b0);
    step();
    fork
      drain("pp_a", 8, 4, 1'b0, 1'b0, fp_a);
      begin
        send_cmd("pp_b", 24, 1, 1'b1);
        fill("pp_b", 3, 1'b1);
        step();
      end
    join
    rd_ready_i = 1'b0;
    @(negedge clk_i);
    check("pp_gap_valid", rd_valid_o, 0);
    check("pp_gap_busy", busy_o, 1);
    step();
    @(negedge clk_i);
    check("pp_b_valid", {rd_valid_o, rd_buf_o}, 2'b11);
    step();
    drain("pp_b", 24, 1, 1'b1, 1'b0, fp_b);
    check("pp_b_first", fp_b, 0);
    rd_ready_i = 1'b0;

    run_s1("s1");

    // Non-power-of-two length: 2 beats, element counter wraps at 10.
    send_cmd("b10", 10, 2, 1'b1);
    fill("b10", 2, 1'b1);
    step();
    drain("b10", 10, 2, 1'b1, 1'b0, fp_a);
    rd_ready_i = 1'b0;

    send_cmd("rnd", 16, 2, 1'b1);
    fill("rnd", 2, 1'b0);
    step();
    drain("rnd", 16, 2, 1'b0, 1'b1, fp_a);
    rd_ready_i = 1'b0;

    // Stray beat while idle.
    wr_beat_i = 1'b1;
    @(negedge clk_i);
    check("err_before", err_o, 0);
    step();
    wr_beat_i = 1'b0;
    @(negedge clk_i);
    check("err_set", {err_o, wr_en_o, busy_o}, 3'b100);
    step();
    @(negedge clk_i);
    check("err_sticky", err_o, 1);
    step();

    send_cmd("x", 8, 2, 1'b1);
    fill("x", 1, 1'b1);
    step();
    send_cmd("y", 8, 1, 1'b1);
    fill("y", 1, 1'b0);
    step();
    cmd_valid_i = 1'b1;
    cmd_blen_i  = 7'd8;
    cmd_reps_i  = 9'd1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      check("z_blocked", cmd_ready_o, 0);
      step();
    end
    cmd_valid_i = 1'b0;
    drain("x", 8, 2, 1'b1, 1'b0, fp_a);
    rd_ready_i = 1'b0;
    @(negedge clk_i);
    check("z_ready_after", {cmd_ready_o, rd_valid_o}, 2'b10);
    step();
    drain("y", 8, 1, 1'b0, 1'b0, fp_a);
    rd_ready_i = 1'b0;
    @(negedge clk_i);
    check("err_still", err_o, 1);
    step();

    // Reset mid-drain at pass 1, element 5.
    send_cmd("s6", 16, 3, 1'b1);
    fill("s6", 2, 1'b1);
    step();
    pops = 0;
    rd_ready_i = 1'b1;
    for (int c = 0; c < 40 && pops < 21; c++) begin
      @(negedge clk_i);
      if (rd_pop_o) pops++;
      step();
    end
    check("s6_prepops", pops, 21);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    @(negedge clk_i);
    check("s6_reset_outs", outs(), 11'b100_0000_0000);
    step();
    rd_ready_i = 1'b0;
    run_s1("s6b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
